// File: rtl/multi_ff_bank.sv
// Bank of WIDTH single-cycle flops with a global SR/JK/D/T function select,
// plus sticky tracking of invalid SR (a=b=1) events.
module multi_ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             sclr,
    input  logic             spre,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] inv_vec;
    logic [WIDTH-1:0] mask_base;
    logic [CNT_W-1:0] cnt_base;
    logic             err_base;
    logic [WIDTH-1:0] mask_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;

    always_comb begin
        q_nxt = q;
        if (sclr) begin
            q_nxt = '0;
        end else if (spre) begin
            q_nxt = '1;
        end else if (en) begin
            case (mode)
                MODE_SR: q_nxt = (q | (a & ~b)) & ~(~a & b);
                MODE_JK: q_nxt = (a & ~b) | (a & b & ~q) | (~a & ~b & q);
                MODE_D:  q_nxt = a;
                MODE_T:  q_nxt = q ^ a;
                default: q_nxt = q;
            endcase
        end
    end

    // Invalid events only count when the SR function would actually have been applied.
    always_comb begin
        inv_vec = '0;
        if (mode == MODE_SR && en && !sclr && !spre) begin
            inv_vec = a & b;
        end
    end

    // err_clr wipes the old record first so same-cycle events survive the clear.
    always_comb begin
        mask_base = err_clr ? '0 : err_mask;
        cnt_base  = err_clr ? '0 : err_cnt;
        err_base  = err_clr ? 1'b0 : err;
        mask_nxt  = mask_base | inv_vec;
        err_nxt   = err_base | (|inv_vec);
        cnt_nxt   = (|inv_vec) ? sat_inc(cnt_base) : cnt_base;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q        <= '0;
            err      <= 1'b0;
            err_mask <= '0;
            err_cnt  <= '0;
        end else begin
            q        <= q_nxt;
            err      <= err_nxt;
            err_mask <= mask_nxt;
            err_cnt  <= cnt_nxt;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_multi_ff_bank.sv
// Directed self-checking bench for multi_ff_bank (WIDTH=8, CNT_W=4).
module tb_multi_ff_bank;

    logic       clk;
    logic       clr_n;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic       sclr;
    logic       spre;
    logic       err_clr;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       err;
    logic [7:0] err_mask;
    logic [3:0] err_cnt;

    int checks = 0;
    int errors = 0;

    multi_ff_bank #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .en       (en),
        .sclr     (sclr),
        .spre     (spre),
        .err_clr  (err_clr),
        .q        (q),
        .qbar     (qbar),
        .err      (err),
        .err_mask (err_mask),
        .err_cnt  (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
        checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h exp %h", qbar, 8'hFF); end
        checks++; if ({err, err_mask, err_cnt} !== 13'h0) begin errors++; $display("FAIL reset_err got %b/%h/%0d exp 0/00/0", err, err_mask, err_cnt); end
        clr_n = 1'b1;
        step(1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_hold_after_release got %h exp %h", q, 8'h00); end
    endtask

    task automatic test_sr_sweep();
        mode = 2'b00; en = 1'b1; a = 8'h0F; b = 8'h00;
        step(1);
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL sr_set_q got %h exp %h", q, 8'h0F); end
        checks++; if (qbar !== 8'hF0) begin errors++; $display("FAIL sr_set_qbar got %h exp %h", qbar, 8'hF0); end
        a = 8'h00; b = 8'h0C;
        step(1);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL sr_reset_q got %h exp %h", q, 8'h03); end
        checks++; if (qbar !== 8'hFC) begin errors++; $display("FAIL sr_reset_qbar got %h exp %h", qbar, 8'hFC); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sr_no_err got %b exp 0", err); end
    endtask

    task automatic test_invalid();
        a = 8'h81; b = 8'h81;
        step(3);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL inv_q_hold got %h exp %h", q, 8'h03); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err got %b exp 1", err); end
        checks++; if (err_mask !== 8'h81) begin errors++; $display("FAIL inv_mask got %h exp %h", err_mask, 8'h81); end
        checks++; if (err_cnt !== 4'd3) begin errors++; $display("FAIL inv_cnt3 got %0d exp 3", err_cnt); end
        step(12);
        checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL inv_cnt_reach_sat got %0d exp 15", err_cnt); end
        step(8);
        checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL inv_cnt_sat_hold got %0d exp 15", err_cnt); end
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL inv_q_hold2 got %h exp %h", q, 8'h03); end
    endtask

    task automatic test_err_clr();
        a = 8'h00; b = 8'h00; err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if ({err, err_mask, err_cnt} !== 13'h0) begin errors++; $display("FAIL clr_from_sat got %b/%h/%0d exp 0/00/0", err, err_mask, err_cnt); end
        a = 8'h81; b = 8'h81;
        step(5);
        checks++; if (err_cnt !== 4'd5) begin errors++; $display("FAIL clr_pre_cnt got %0d exp 5", err_cnt); end
        a = 8'h04; b = 8'h04; err_clr = 1'b1;
        step(1);
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL clr_collide_cnt got %0d exp 1", err_cnt); end
        checks++; if (err_mask !== 8'h04) begin errors++; $display("FAIL clr_collide_mask got %h exp %h", err_mask, 8'h04); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_collide_err got %b exp 1", err); end
        a = 8'h00; b = 8'h00;
        step(1);
        err_clr = 1'b0;
        checks++; if ({err, err_mask, err_cnt} !== 13'h0) begin errors++; $display("FAIL clr_alone got %b/%h/%0d exp 0/00/0", err, err_mask, err_cnt); end
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL clr_q_unchanged got %h exp %h", q, 8'h03); end
    endtask

    task automatic test_jk_t();
        sclr = 1'b1;
        step(1);
        sclr = 1'b0;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL jk_start got %h exp %h", q, 8'h00); end
        mode = 2'b01; a = 8'hFF; b = 8'hFF;
        step(1);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL jk_tog1 got %h exp %h", q, 8'hFF); end
        step(1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL jk_tog2 got %h exp %h", q, 8'h00); end
        step(1);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL jk_tog3 got %h exp %h", q, 8'hFF); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL jk_no_err got %b exp 0", err); end
        a = 8'h30; b = 8'h0C;
        step(1);
        checks++; if (q !== 8'hF3) begin errors++; $display("FAIL jk_set_reset got %h exp %h", q, 8'hF3); end
        mode = 2'b11; a = 8'h01; b = 8'hFF;
        step(1);
        checks++; if (q !== 8'hF2) begin errors++; $display("FAIL t_tog1 got %h exp %h", q, 8'hF2); end
        step(1);
        checks++; if (q !== 8'hF3) begin errors++; $display("FAIL t_tog2 got %h exp %h", q, 8'hF3); end
    endtask

    task automatic test_priority();
        sclr = 1'b1; spre = 1'b1;
        step(1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL pri_sclr_spre got %h exp %h", q, 8'h00); end
        sclr = 1'b0;
        step(1);
        spre = 1'b0;
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL pri_spre got %h exp %h", q, 8'hFF); end
        mode = 2'b10; en = 1'b0; a = 8'h5A;
        step(1);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL pri_en0_hold got %h exp %h", q, 8'hFF); end
        en = 1'b1;
        step(1);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL d_load got %h exp %h", q, 8'h5A); end
        mode = 2'b00; a = 8'h01; b = 8'h01;
        step(1);
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL pri_pre_cnt got %0d exp 1", err_cnt); end
        sclr = 1'b1; a = 8'hFF; b = 8'hFF;
        step(1);
        sclr = 1'b0;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL pri_sclr_sr got %h exp %h", q, 8'h00); end
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL pri_sclr_no_inc got %0d exp 1", err_cnt); end
        checks++; if (err_mask !== 8'h01) begin errors++; $display("FAIL pri_sclr_keep_mask got %h exp %h", err_mask, 8'h01); end
        en = 1'b0;
        step(1);
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL pri_en0_no_inc got %0d exp 1", err_cnt); end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        a = 8'h00; b = 8'h00; err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        mode = 2'b10; a = 8'hA5;
        step(1);
        mode = 2'b00; a = 8'h01; b = 8'h01;
        step(7);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL ar_pre_q got %h exp %h", q, 8'hA5); end
        checks++; if (err_cnt !== 4'd7) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 7", err_cnt); end
        mode = 2'b10; a = 8'h3C;
        #2 clr_n = 1'b0;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL ar_q got %h exp %h", q, 8'h00); end
        checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL ar_qbar got %h exp %h", qbar, 8'hFF); end
        checks++; if ({err, err_mask, err_cnt} !== 13'h0) begin errors++; $display("FAIL ar_err got %b/%h/%0d exp 0/00/0", err, err_mask, err_cnt); end
        #2 clr_n = 1'b1;
        step(1);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL ar_first_load got %h exp %h", q, 8'h3C); end
        #2 clr_n = 1'b0;
        a = 8'hC3;
        step(1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL ar_edge_ignored got %h exp %h", q, 8'h00); end
        #2 clr_n = 1'b1;
        step(1);
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL ar_second_load got %h exp %h", q, 8'hC3); end
    endtask

    initial begin
        clr_n = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00;
        en = 1'b0; sclr = 1'b0; spre = 1'b0; err_clr = 1'b0;
        test_reset();
        test_sr_sweep();
        test_invalid();
        test_err_clr();
        test_jk_t();
        test_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_ff_bank.md
MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent flop channels, 1 to 32.
REQ-002 SHALL have parameter CNT_W, default 4: width of the invalid-event counter, 1 to 16.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port clr_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 2: global function select. 00 SR, 01 JK, 10 D, 11 T.
REQ-006 SHALL have port a, input, WIDTH: per-channel S, J, D or T input.
REQ-007 SHALL have port b, input, WIDTH: per-channel R or K input; ignored in D and T modes.
REQ-008 SHALL have port en, input, 1: load enable; when 0, q holds.
REQ-009 SHALL have port sclr, input, 1: synchronous clear of all channels.
REQ-010 SHALL have port spre, input, 1: synchronous preset of all channels.
REQ-011 SHALL have port err_clr, input, 1: synchronous clear of the error state.
REQ-012 SHALL have port q, output, WIDTH: flop state.
REQ-013 SHALL have port qbar, output, WIDTH: bitwise complement of q at all times.
REQ-014 SHALL have port err, output, 1: sticky flag indicating that an invalid SR event occurred.
REQ-015 SHALL have port err_mask, output, WIDTH: sticky per-channel record of invalid SR events.
REQ-016 SHALL have port err_cnt, output, CNT_W: saturating count of cycles that contained at least one invalid event.

Function
REQ-017 SHALL apply this update priority at each clk rising edge: sclr > spre > en=0 (hold) > mode function; if sclr=1 and spre=1 together, q SHALL become all zeros.
REQ-018 SR mode, per channel (a,b): 00 hold; 10 sets q=1; 01 sets q=0; 11 is invalid, q holds.
REQ-019 JK mode, per channel (a,b): 00 hold; 10 sets q=1; 01 sets q=0; 11 toggles q.
REQ-020 D mode: q SHALL load a on the edge; b is ignored.
REQ-021 T mode: q SHALL toggle where a=1 and hold where a=0; b is ignored.
REQ-022 SHALL complete every update in one cycle: q reflects the inputs sampled at edge N immediately after edge N, with no further pipeline delay.
REQ-023 SHALL apply a mode change on the edge at which the new mode is sampled; q SHALL NOT be modified by the mode change itself.
REQ-024 SHALL record an invalid event only when all of the following hold: mode=00, en=1, sclr=0, spre=0, and a[i]=b[i]=1.
REQ-025 On a recorded invalid event, SHALL set err_mask[i] for each offending channel and set err.
REQ-026 On a recorded invalid event, SHALL increment err_cnt by exactly 1 per cycle, regardless of how many channels are invalid.
REQ-027 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 err_clr=1 SHALL zero err, err_mask and err_cnt, then apply any invalid events of that same cycle: err=1, err_mask equal to the offending channels, err_cnt=1.
REQ-029 err_clr SHALL NOT affect q.
REQ-030 sclr, spre and en SHALL NOT clear the error state.

Reset
REQ-031 clr_n=0 SHALL immediately, without waiting for clk, force q=0, qbar=all ones, err=0, err_mask=0 and err_cnt=0.
REQ-032 While clr_n=0, SHALL ignore all clk edges and inputs.
REQ-033 Reset asserted mid-operation SHALL discard state, including a saturated err_cnt.
REQ-034 After clr_n deasserts, the first clk rising edge SHALL perform a normal update.

Verification
REQ-035 Bench SHALL cover SR sweep: WIDTH=8, mode=00, en=1, a=0x0F/b=0x00, then a=0x00/b=0x0C -> q=0x0F then 0x03; qbar=0xF0 then 0xFC.
REQ-036 Bench SHALL cover invalid events: q=0x03, a=b=0x81 for 3 cycles -> q stays 0x03, err=1, err_mask=0x81, err_cnt=3; a further 20 invalid cycles with CNT_W=4 -> err_cnt=15, held.
REQ-037 Bench SHALL cover JK/T toggle: mode=01, a=b=0xFF from q=0x00 -> q alternates 0xFF/0x00 each cycle; mode=11, a=0x01 -> bit 0 toggles, others hold.
REQ-038 Bench SHALL cover priority: sclr=1 with spre=1 -> q=0x00; spre alone -> q=0xFF; en=0 in D mode with a=0x5A -> q unchanged; sclr=1 with a=b=0xFF in SR mode -> no err increment.
REQ-039 Bench SHALL cover err_clr collision: err_cnt=5, err_clr=1 together with an invalid event on channel 2 -> err_cnt=1, err_mask=0x04, err=1; err_clr alone on the next cycle -> all zero, q unchanged.
REQ-040 Bench SHALL cover async reset: clr_n pulsed low between clk edges while q=0xA5 and err_cnt=7 -> q=0x00, qbar=0xFF and err_cnt=0 before the next clk edge; the first edge after release loads normally.
